// File: rtl/cnn_cell_scheduler.sv
// CNN cell-update sequencer: walks a W x H grid, accumulates the 3x3 A*Y + B*U
// neighbourhood plus bias through one serial MAC, and writes the clamped result to the opposite bank.
module cnn_cell_scheduler #(
  parameter int W      = 8,
  parameter int H      = 8,
  parameter int ADDR_W = $clog2(W*H),
  parameter int ACC_W  = 21,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        iters,
  input  logic [71:0]       a_flat,
  input  logic [71:0]       b_flat,
  input  logic [7:0]        bias,
  output logic              busy,
  output logic              done,
  output logic              bank,
  output logic              rd_en,
  output logic [ADDR_W:0]   rd_addr,
  input  logic [8:0]        rd_y,
  input  logic [7:0]        rd_u,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [8:0]        wr_data
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(255);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-256);

  typedef enum logic [2:0] {S_IDLE, S_TAP, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [71:0]              a_q, a_d, b_q, b_d;
  logic [7:0]               bias_q, bias_d;
  logic [7:0]               passes_q, passes_d;
  logic                     bank_q, bank_d;
  logic [3:0]               tap_q, tap_d;
  logic [CW-1:0]            col_q, col_d;
  logic [RW-1:0]            row_q, row_d;
  logic                     vld_q, vld_d;
  logic [3:0]               vtap_q, vtap_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  logic                     last_cell;
  logic                     in_bounds;
  logic [ADDR_W-1:0]        nbr_idx;
  logic [ADDR_W-1:0]        cell_idx;
  logic signed [7:0]        a_t, b_t;
  logic signed [16:0]       prod_a;
  logic signed [15:0]       prod_b;
  logic signed [ACC_W-1:0]  shifted;
  logic [8:0]               sat_val;

  assign last_cell = (col_q == CW'(W-1)) && (row_q == RW'(H-1));
  assign cell_idx  = ADDR_W'(int'(row_q) * W + int'(col_q));

  // Neighbour coordinates for the current tap; taps run dy outer, dx inner.
  always_comb begin
    int dy, dx, nr, nc;
    dy = int'(tap_q) / 3;
    dx = int'(tap_q) % 3;
    nr = int'(row_q) + dy - 1;
    nc = int'(col_q) + dx - 1;
    in_bounds = (nr >= 0) && (nr < H) && (nc >= 0) && (nc < W);
    nbr_idx   = in_bounds ? ADDR_W'(nr * W + nc) : '0;
  end

  always_comb begin
    a_t    = $signed(a_q[8*vtap_q +: 8]);
    b_t    = $signed(b_q[8*vtap_q +: 8]);
    prod_a = a_t * $signed(rd_y);
    prod_b = b_t * $signed(rd_u);
  end

  always_comb begin
    shifted = acc_q >>> SHIFT;
    if (shifted > SAT_HI)      sat_val = 9'h0FF;
    else if (shifted < SAT_LO) sat_val = 9'h100;
    else                       sat_val = shifted[8:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_TAP;
      S_TAP:   if (tap_q == 4'd8) state_d = S_DRAIN;
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: state_d = (last_cell && passes_q <= 8'd1) ? S_DONE : S_TAP;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath / counter next values
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    bias_d   = bias_q;
    passes_d = passes_q;
    bank_d   = bank_q;
    tap_d    = tap_q;
    col_d    = col_q;
    row_d    = row_q;
    vld_d    = (state_q == S_TAP) && in_bounds;
    vtap_d   = tap_q;
    acc_d    = acc_q;
    if (vld_q)
      acc_d = acc_q + {{(ACC_W-17){prod_a[16]}}, prod_a} + {{(ACC_W-16){prod_b[15]}}, prod_b};
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = a_flat;
          b_d      = b_flat;
          bias_d   = bias;
          passes_d = (iters == 8'd0) ? 8'd1 : iters;
          tap_d    = '0;
          col_d    = '0;
          row_d    = '0;
        end
      end
      S_TAP: begin
        if (tap_q == 4'd0) acc_d = {{(ACC_W-8){bias_q[7]}}, bias_q};
        tap_d = (tap_q == 4'd8) ? 4'd0 : tap_q + 4'd1;
      end
      S_WRITE: begin
        tap_d = '0;
        if (last_cell) begin
          col_d = '0;
          row_d = '0;
          if (passes_q > 8'd1) begin
            passes_d = passes_q - 8'd1;
            bank_d   = ~bank_q;
          end
        end else if (col_q == CW'(W-1)) begin
          col_d = '0;
          row_d = row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      bias_q   <= '0;
      passes_q <= '0;
      bank_q   <= 1'b0;
      tap_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      vld_q    <= 1'b0;
      vtap_q   <= '0;
      acc_q    <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      bias_q   <= bias_d;
      passes_q <= passes_d;
      bank_q   <= bank_d;
      tap_q    <= tap_d;
      col_q    <= col_d;
      row_q    <= row_d;
      vld_q    <= vld_d;
      vtap_q   <= vtap_d;
      acc_q    <= acc_d;
    end
  end

  // Outputs decode from the state register so an async reset clears them at once.
  always_comb begin
    busy    = (state_q == S_TAP) || (state_q == S_DRAIN) || (state_q == S_WRITE);
    done    = (state_q == S_DONE);
    bank    = bank_q;
    rd_en   = (state_q == S_TAP) && in_bounds;
    rd_addr = rd_en ? {bank_q, nbr_idx} : '0;
    wr_en   = (state_q == S_WRITE);
    wr_addr = wr_en ? {~bank_q, cell_idx} : '0;
    wr_data = wr_en ? sat_val : '0;
  end

endmodule

// File: tb/tb_cnn_cell_scheduler.sv
// Directed bench for cnn_cell_scheduler: behavioural state/input RAM, per-scenario tasks
// with hand-computed expectations for values, padding, saturation, banking and timing.
module tb_cnn_cell_scheduler;

  localparam int PASS_CYC = 704;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  iters = 8'd1;
  logic [71:0] a_flat = '0;
  logic [71:0] b_flat = '0;
  logic [7:0]  bias = '0;
  logic        busy, done, bank, rd_en, wr_en;
  logic [6:0]  rd_addr, wr_addr;
  logic [8:0]  rd_y = '0;
  logic [7:0]  rd_u = '0;
  logic [8:0]  wr_data;

  logic [8:0]  mem_y [0:127];
  logic [7:0]  mem_u [0:127];
  logic        fill_req = 1'b0;
  logic        fill_bank = 1'b0;
  logic [8:0]  fill_y = '0;
  logic [7:0]  fill_u = '0;

  int errors = 0;
  int checks = 0;
  int wr_cnt, rd_cnt, corner_rd, bad_bank, overlap, done_cyc;

  cnn_cell_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .iters(iters),
    .a_flat(a_flat), .b_flat(b_flat), .bias(bias),
    .busy(busy), .done(done), .bank(bank),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_y(rd_y), .rd_u(rd_u),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 64; i++) mem_y[int'(fill_bank) * 64 + i] <= fill_y;
      for (int i = 0; i < 128; i++) mem_u[i] <= fill_u;
    end else begin
      if (rd_en) begin
        rd_y <= mem_y[rd_addr];
        rd_u <= mem_u[rd_addr];
      end
      if (wr_en) mem_y[wr_addr] <= wr_data;
    end
  end

  task automatic fill(input logic bk, input logic [8:0] y, input logic [7:0] u);
    @(negedge clk);
    fill_bank = bk; fill_y = y; fill_u = u; fill_req = 1'b1;
    @(negedge clk);
    fill_req = 1'b0;
  endtask

  task automatic set_tmpl(input logic [7:0] a_all, input logic [7:0] a_ctr,
                          input logic [7:0] b_all, input logic [7:0] bi);
    for (int t = 0; t < 9; t++) begin
      a_flat[8*t +: 8] = (t == 4) ? a_ctr : a_all;
      b_flat[8*t +: 8] = b_all;
    end
    bias = bi;
  endtask

  task automatic run_op(input logic [7:0] it, input int restart_k);
    logic b0;
    int   p;
    b0 = bank; wr_cnt = 0; rd_cnt = 0; corner_rd = 0; bad_bank = 0; overlap = 0; done_cyc = -1;
    @(negedge clk);
    iters = it; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20000; k++) begin
      @(negedge clk);
      start = (k == restart_k);
      p = (k - 1) / PASS_CYC;
      if (rd_en && wr_en) overlap++;
      if (rd_en) begin
        rd_cnt++;
        if (k <= 9) corner_rd++;
        if (rd_addr[6] !== (b0 ^ p[0])) bad_bank++;
      end
      if (wr_en) begin
        wr_cnt++;
        if (wr_addr[6] !== ~(b0 ^ p[0])) bad_bank++;
      end
      if (done) begin
        done_cyc = k;
        break;
      end
    end
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL op_timeout: done never seen, required within 20000 cycles");
    end
    $display("op iters=%0d done_cycle=%0d reads=%0d writes=%0d bank=%0d", it, done_cyc, rd_cnt, wr_cnt, bank);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, bank, rd_en, wr_en} !== 5'b0 || rd_addr !== 7'd0 || wr_addr !== 7'd0 || wr_data !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b bank=%b rd_en=%b wr_en=%b, required all 0", busy, done, bank, rd_en, wr_en);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_identity;
    fill(1'b0, 9'd5, 8'd0);
    set_tmpl(8'd0, 8'd1, 8'd0, 8'd0);
    run_op(8'd1, 0);
    checks++;
    if (done_cyc !== 705) begin errors++; $display("FAIL identity_done_cycle: got %0d required 705", done_cyc); end
    checks++;
    if (wr_cnt !== 64) begin errors++; $display("FAIL identity_writes: got %0d required 64", wr_cnt); end
    checks++;
    if (rd_cnt !== 484) begin errors++; $display("FAIL identity_reads: got %0d required 484", rd_cnt); end
    checks++;
    if (mem_y[64] !== 9'd5 || mem_y[64+27] !== 9'd5 || mem_y[127] !== 9'd5) begin
      errors++;
      $display("FAIL identity_data: got %0d/%0d/%0d required 5/5/5", mem_y[64], mem_y[91], mem_y[127]);
    end
    checks++;
    if (overlap !== 0 || bad_bank !== 0) begin
      errors++;
      $display("FAIL identity_strobes: overlap=%0d bad_bank=%0d required 0/0", overlap, bad_bank);
    end
  endtask

  task automatic test_padding;
    fill(1'b0, 9'd1, 8'd0);
    set_tmpl(8'd1, 8'd1, 8'd0, 8'd0);
    run_op(8'd1, 0);
    checks++;
    if (mem_y[64] !== 9'd4 || mem_y[127] !== 9'd4) begin
      errors++; $display("FAIL padding_corner: got %0d/%0d required 4/4", mem_y[64], mem_y[127]);
    end
    checks++;
    if (mem_y[65] !== 9'd6 || mem_y[64+8] !== 9'd6) begin
      errors++; $display("FAIL padding_edge: got %0d/%0d required 6/6", mem_y[65], mem_y[72]);
    end
    checks++;
    if (mem_y[64+9] !== 9'd9 || mem_y[64+36] !== 9'd9) begin
      errors++; $display("FAIL padding_interior: got %0d/%0d required 9/9", mem_y[73], mem_y[100]);
    end
    checks++;
    if (corner_rd !== 4) begin errors++; $display("FAIL padding_corner_reads: got %0d required 4", corner_rd); end
  endtask

  task automatic test_saturation;
    fill(1'b0, 9'd127, 8'd0);
    set_tmpl(8'd0, 8'd127, 8'd0, 8'd0);
    run_op(8'd1, 0);
    checks++;
    if (mem_y[64+27] !== 9'h0FF) begin errors++; $display("FAIL sat_pos: got %0d required 255", $signed(mem_y[91])); end
    fill(1'b0, 9'd255, 8'd0);
    set_tmpl(8'd0, 8'h80, 8'd0, 8'd0);
    run_op(8'd1, 0);
    checks++;
    if (mem_y[64+27] !== 9'h100) begin errors++; $display("FAIL sat_neg: got %0d required -256", $signed(mem_y[91])); end
  endtask

  task automatic test_input_bias;
    fill(1'b0, 9'd7, 8'd2);
    set_tmpl(8'd0, 8'd0, 8'd1, 8'hFD);
    run_op(8'd1, 0);
    checks++;
    if (mem_y[64+9] !== 9'd15) begin errors++; $display("FAIL bias_interior: got %0d required 15", mem_y[73]); end
    checks++;
    if (mem_y[64] !== 9'd5) begin errors++; $display("FAIL bias_corner: got %0d required 5", mem_y[64]); end
    checks++;
    if (mem_y[64+3] !== 9'd9) begin errors++; $display("FAIL bias_edge: got %0d required 9", mem_y[67]); end
  endtask

  task automatic test_multi_pass;
    fill(1'b0, 9'd1, 8'd0);
    set_tmpl(8'd1, 8'd1, 8'd0, 8'd0);
    run_op(8'd2, 0);
    checks++;
    if (done_cyc !== 1409) begin errors++; $display("FAIL multi_done_cycle: got %0d required 1409", done_cyc); end
    checks++;
    if (bad_bank !== 0 || overlap !== 0) begin
      errors++; $display("FAIL multi_banks: bad_bank=%0d overlap=%0d required 0/0", bad_bank, overlap);
    end
    checks++;
    if (mem_y[0] !== 9'd25 || mem_y[1] !== 9'd40) begin
      errors++; $display("FAIL multi_data: got %0d/%0d required 25/40", mem_y[0], mem_y[1]);
    end
    checks++;
    if (bank !== 1'b1) begin errors++; $display("FAIL multi_bank_out: got %b required 1", bank); end
  endtask

  task automatic test_iters_zero;
    fill(1'b1, 9'd5, 8'd0);
    set_tmpl(8'd0, 8'd1, 8'd0, 8'd0);
    run_op(8'd0, 0);
    checks++;
    if (done_cyc !== 705 || wr_cnt !== 64) begin
      errors++; $display("FAIL iters_zero: done=%0d writes=%0d required 705/64", done_cyc, wr_cnt);
    end
    checks++;
    if (bad_bank !== 0 || bank !== 1'b1 || mem_y[10] !== 9'd5) begin
      errors++; $display("FAIL iters_zero_bank: bad_bank=%0d bank=%b data=%0d required 0/1/5", bad_bank, bank, mem_y[10]);
    end
  endtask

  task automatic test_start_while_busy;
    run_op(8'd1, 50);
    checks++;
    if (done_cyc !== 705 || wr_cnt !== 64) begin
      errors++; $display("FAIL start_busy: done=%0d writes=%0d required 705/64", done_cyc, wr_cnt);
    end
  endtask

  task automatic test_reset_abort;
    int ws;
    @(negedge clk);
    iters = 8'd1; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 114; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1 || rd_en !== 1'b1 || rd_addr[5:0] !== 6'd9) begin
      errors++; $display("FAIL abort_pre: busy=%b rd_en=%b rd_addr=%0d required 1/1/9", busy, rd_en, rd_addr[5:0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, rd_en, wr_en, done, bank} !== 5'b0) begin
      errors++; $display("FAIL abort_outputs: busy=%b rd_en=%b wr_en=%b done=%b bank=%b required 0", busy, rd_en, wr_en, done, bank);
    end
    ws = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rd_en || wr_en || busy) ws++;
    end
    checks++;
    if (ws !== 0) begin errors++; $display("FAIL abort_quiet: active cycles=%0d required 0", ws); end
    rst_n = 1'b1;
    $display("op reset abort at cell 10 tap 3");
  endtask

  initial begin
    test_reset;
    test_identity;
    test_padding;
    test_saturation;
    test_input_bias;
    test_multi_pass;
    test_iters_zero;
    test_start_while_busy;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
